// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : IF-stage program counter. Resolves branch, jump and jr
//             redirects from ID with MIPS delay-slot semantics. A redirect
//             that arrives during a stall is held and applied once the
//             stall clears.
//  Options  : define PC_GEN_EXC_EN to add exception entry / eret ports.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int unsigned     AW         = 32,
  parameter logic [AW-1:0]   RESET_PC   = 32'h0000_3000,
  parameter logic [AW-1:0]   EXC_VECTOR = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redir_valid,
  input  logic [1:0]    redir_sel,
  input  logic          br_taken,
  input  logic [AW-1:0] id_pc,
  input  logic [25:0]   imm26,
  input  logic [AW-1:0] ra,
`ifdef PC_GEN_EXC_EN
  input  logic          exc_req,
  input  logic          eret,
  input  logic [AW-1:0] epc,
`endif
  output logic [AW-1:0] pc,
  output logic [AW-1:0] id_link,
  output logic          pend,
  output logic          misalign
);

  localparam logic [1:0]    c_sel_branch = 2'd0;
  localparam logic [1:0]    c_sel_jump   = 2'd1;
  localparam logic [1:0]    c_sel_jr     = 2'd2;
  localparam logic [AW-1:0] c_four       = AW'(4);
  localparam logic [AW-1:0] c_eight      = AW'(8);

  logic [AW-1:0] r_pend_addr;
  logic [AW-1:0] w_id_pc_plus4;
  logic [AW-1:0] w_br_off;
  logic [AW-1:0] w_br_target;
  logic [AW-1:0] w_jump_target;
  logic [AW-1:0] w_target;
  logic          w_taken;
  logic [AW-1:0] w_next_pc;
  logic          w_next_pend;
  logic [AW-1:0] w_next_pend_addr;

  assign w_id_pc_plus4 = id_pc + c_four;
  assign id_link       = id_pc + c_eight;

  // Branch offset: sign-extended 16-bit word offset.
  assign w_br_off    = {{(AW-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign w_br_target = w_id_pc_plus4 + w_br_off;

  // Jump target keeps the 256 MB region bits of the delay-slot PC, if any exist.
  generate
    if (AW > 28) begin : g_jump_region
      assign w_jump_target = {w_id_pc_plus4[AW-1:28], imm26, 2'b00};
    end else begin : g_jump_flat
      assign w_jump_target = {imm26, 2'b00};
    end
  endgenerate

  // Decode the redirect kind and pick its target; reserved kind never redirects.
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_br_target;
    case (redir_sel)
      c_sel_branch: begin
        w_taken  = redir_valid & br_taken;
        w_target = w_br_target;
      end
      c_sel_jump: begin
        w_taken  = redir_valid;
        w_target = w_jump_target;
      end
      c_sel_jr: begin
        w_taken  = redir_valid;
        w_target = ra;
      end
      default: begin
        w_taken  = 1'b0;
        w_target = w_br_target;
      end
    endcase
    // ID is frozen while a redirect is held, so its re-presented request is stale.
    if (pend) begin
      w_taken = 1'b0;
    end
  end

  // Next-PC priority: exceptions, stall hold, held redirect, live redirect, +4.
  always_comb begin
    w_next_pc        = pc + c_four;
    w_next_pend      = 1'b0;
    w_next_pend_addr = r_pend_addr;
`ifdef PC_GEN_EXC_EN
    if (exc_req) begin
      w_next_pc = EXC_VECTOR;
    end else if (eret) begin
      w_next_pc = epc;
    end else
`endif
    if (stall) begin
      w_next_pc   = pc;
      w_next_pend = pend | w_taken;
      if (w_taken) begin
        w_next_pend_addr = w_target;
      end
    end else if (pend) begin
      w_next_pc = r_pend_addr;
    end else if (w_taken) begin
      w_next_pc = w_target;
    end
  end

  // PC, hold register and alignment flag; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      pend        <= 1'b0;
      r_pend_addr <= '0;
      misalign    <= (RESET_PC[1:0] != 2'b00);
    end else begin
      pc          <= w_next_pc;
      pend        <= w_next_pend;
      r_pend_addr <= w_next_pend_addr;
      misalign    <= (w_next_pc[1:0] != 2'b00);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Self-checking bench for pc_gen: vector table plus hand-written
//             stall / reset / exception sequences, scoreboard-compared.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          redir_valid;
  logic [1:0]    redir_sel;
  logic          br_taken;
  logic [AW-1:0] id_pc;
  logic [25:0]   imm26;
  logic [AW-1:0] ra;
`ifdef PC_GEN_EXC_EN
  logic          exc_req;
  logic          eret;
  logic [AW-1:0] epc;
`endif
  logic [AW-1:0] pc;
  logic [AW-1:0] id_link;
  logic          pend;
  logic          misalign;

  pc_gen #(
    .AW         (AW),
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_sel   (redir_sel),
    .br_taken    (br_taken),
    .id_pc       (id_pc),
    .imm26       (imm26),
    .ra          (ra),
`ifdef PC_GEN_EXC_EN
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
`endif
    .pc          (pc),
    .id_link     (id_link),
    .pend        (pend),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic          rv;
    logic [1:0]    sel;
    logic          bt;
    logic [AW-1:0] id_pc;
    logic [25:0]   imm;
    logic [AW-1:0] ra;
    logic [AW-1:0] exp_pc;
    logic          exp_pend;
    logic          exp_mis;
    logic [AW-1:0] exp_link;
  } vec_t;

  typedef struct {
    string         name;
    logic [AW-1:0] pc;
    logic          pend;
    logic          mis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[18];

  task automatic drive(input logic s, input logic rv, input logic [1:0] sel,
                       input logic bt, input logic [AW-1:0] ip,
                       input logic [25:0] im, input logic [AW-1:0] r);
    stall = s; redir_valid = rv; redir_sel = sel; br_taken = bt;
    id_pc = ip; imm26 = im; ra = r;
  endtask

  task automatic compare_now(input string name, input logic [AW-1:0] epc_v,
                             input logic ep, input logic em);
    checks++;
    if (pc !== epc_v || pend !== ep || misalign !== em) begin
      errors++;
      $display("FAIL %s: got pc=%h pend=%b misalign=%b, want pc=%h pend=%b misalign=%b",
               name, pc, pend, misalign, epc_v, ep, em);
    end
  endtask

  // Push expectation, advance one edge, pop and compare the DUT's response.
  task automatic step(input string name, input logic [AW-1:0] epc_v,
                      input logic ep, input logic em);
    exp_t e;
    exp_t got;
    e.name = name; e.pc = epc_v; e.pend = ep; e.mis = em;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries want 1", name);
    end else begin
      got = sb.pop_front();
      compare_now(got.name, got.pc, got.pend, got.mis);
    end
  endtask

  task automatic check_link(input string name, input logic [AW-1:0] want);
    checks++;
    if (id_link !== want) begin
      errors++;
      $display("FAIL %s: got id_link=%h want %h", name, id_link, want);
    end
  endtask

  initial begin
    // Vector table: each row is one cycle of stimulus and the PC state after the edge.
    //            stall rv sel   bt id_pc         imm26         ra            exp_pc        pend mis link
    vecs[0]  = '{1'b0,1'b0,2'd0,1'b0,32'h0000_0000,26'h0,       32'h0,        32'h0000_3004,1'b0,1'b0,32'h0000_0008};
    vecs[1]  = '{1'b0,1'b0,2'd0,1'b0,32'h0000_0000,26'h0,       32'h0,        32'h0000_3008,1'b0,1'b0,32'h0000_0008};
    vecs[2]  = '{1'b0,1'b1,2'd0,1'b1,32'h0000_3010,26'h000FFFC, 32'h0,        32'h0000_3004,1'b0,1'b0,32'h0000_3018};
    vecs[3]  = '{1'b0,1'b1,2'd2,1'b0,32'h0000_3000,26'h0,       32'h0000_3014,32'h0000_3014,1'b0,1'b0,32'h0000_3008};
    vecs[4]  = '{1'b0,1'b1,2'd0,1'b0,32'h0000_3010,26'h000FFFC, 32'h0,        32'h0000_3018,1'b0,1'b0,32'h0000_3018};
    vecs[5]  = '{1'b0,1'b1,2'd1,1'b0,32'h0000_3000,26'h0000C10, 32'h0,        32'h0000_3040,1'b0,1'b0,32'h0000_3008};
    vecs[6]  = '{1'b0,1'b1,2'd3,1'b1,32'h0000_3000,26'h0000C10, 32'h0000_5000,32'h0000_3044,1'b0,1'b0,32'h0000_3008};
    vecs[7]  = '{1'b0,1'b1,2'd2,1'b0,32'h0000_3040,26'h0,       32'h0000_3022,32'h0000_3022,1'b0,1'b1,32'h0000_3048};
    vecs[8]  = '{1'b0,1'b0,2'd0,1'b0,32'h0000_3040,26'h0,       32'h0,        32'h0000_3026,1'b0,1'b1,32'h0000_3048};
    vecs[9]  = '{1'b1,1'b1,2'd2,1'b0,32'h0000_3044,26'h0,       32'h0000_3100,32'h0000_3026,1'b1,1'b1,32'h0000_304C};
    vecs[10] = '{1'b1,1'b1,2'd2,1'b0,32'h0000_3044,26'h0,       32'h0000_5000,32'h0000_3026,1'b1,1'b1,32'h0000_304C};
    vecs[11] = '{1'b1,1'b0,2'd0,1'b0,32'h0000_3044,26'h0,       32'h0,        32'h0000_3026,1'b1,1'b1,32'h0000_304C};
    vecs[12] = '{1'b0,1'b1,2'd2,1'b0,32'h0000_3044,26'h0,       32'h0000_5000,32'h0000_3100,1'b0,1'b0,32'h0000_304C};
    vecs[13] = '{1'b0,1'b0,2'd0,1'b0,32'h0000_3100,26'h0,       32'h0,        32'h0000_3104,1'b0,1'b0,32'h0000_3108};
    vecs[14] = '{1'b1,1'b0,2'd0,1'b0,32'h0000_3100,26'h0,       32'h0,        32'h0000_3104,1'b0,1'b0,32'h0000_3108};
    vecs[15] = '{1'b0,1'b1,2'd1,1'b0,32'hF000_0010,26'h3FFFFFF, 32'h0,        32'hFFFF_FFFC,1'b0,1'b0,32'hF000_0018};
    vecs[16] = '{1'b0,1'b1,2'd0,1'b1,32'hFFFF_FFF8,26'h0000001, 32'h0,        32'h0000_0000,1'b0,1'b0,32'h0000_0000};
    vecs[17] = '{1'b0,1'b0,2'd0,1'b0,32'h0000_0000,26'h0,       32'h0,        32'h0000_0004,1'b0,1'b0,32'h0000_0008};

    reset = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
`ifdef PC_GEN_EXC_EN
    exc_req = 1'b0; eret = 1'b0; epc = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    compare_now("reset_state", 32'h0000_3000, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].sel, vecs[i].bt,
            vecs[i].id_pc, vecs[i].imm, vecs[i].ra);
      #1;
      check_link($sformatf("link_v%0d", i), vecs[i].exp_link);
      step($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pend, vecs[i].exp_mis);
    end

    // Reset while a redirect is held must discard it.
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0000, '0, 32'h0000_7000);
    step("hold_before_reset", 32'h0000_0004, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    compare_now("async_reset_mid_pend", 32'h0000_3000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step("after_reset_no_target", 32'h0000_3004, 1'b0, 1'b0);

`ifdef PC_GEN_EXC_EN
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_3000, '0, 32'h0000_3100);
    step("exc_setup_pend", 32'h0000_3004, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_3000, '0, '0);
    exc_req = 1'b1;
    step("exc_over_stall_pend", 32'h0000_4180, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
    eret = 1'b1; epc = 32'h0000_3022;
    step("exc_beats_eret", 32'h0000_4180, 1'b0, 1'b0);
    exc_req = 1'b0;
    step("eret_misaligned", 32'h0000_3022, 1'b0, 1'b1);
    eret = 1'b0;
    step("after_eret", 32'h0000_3026, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion, want completion before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
